// File: rtl/store_queue_if.sv
// Store-queue port bundle: dispatch/FU/ROB side plus the D-cache store port.
// Latency: none (signal container only).
// Backpressure: store_en/store_accepted handshake; allocation gated by full.
// Ports (slave = queue side):
//   alloc_en/alloc_size -> alloc_idx/full/empty/count   dispatch allocation
//   exec_en/exec_idx/exec_addr/exec_data                store FU writeback
//   commit_en, flush                                    ROB retire / squash
//   proc2Dcache_addr_store/data_store, is_32_bit, is_16_bit, store_en -> cache
//   store_accepted                                      <- cache
interface store_queue_if #(
  parameter int SQ_DEPTH = 8,
  parameter int IDX_W    = $clog2(SQ_DEPTH)
);
  logic             alloc_en;
  logic [1:0]       alloc_size;
  logic [IDX_W-1:0] alloc_idx;
  logic             full;
  logic             empty;
  logic [IDX_W:0]   count;
  logic             exec_en;
  logic [IDX_W-1:0] exec_idx;
  logic [31:0]      exec_addr;
  logic [31:0]      exec_data;
  logic             commit_en;
  logic             flush;
  logic [31:0]      proc2Dcache_addr_store;
  logic [31:0]      proc2Dcache_data_store;
  logic             is_32_bit;
  logic             is_16_bit;
  logic             store_en;
  logic             store_accepted;

  modport slave (
    input  alloc_en, alloc_size, exec_en, exec_idx, exec_addr, exec_data,
           commit_en, flush, store_accepted,
    output alloc_idx, full, empty, count, proc2Dcache_addr_store,
           proc2Dcache_data_store, is_32_bit, is_16_bit, store_en
  );

  modport master (
    output alloc_en, alloc_size, exec_en, exec_idx, exec_addr, exec_data,
           commit_en, flush, store_accepted,
    input  alloc_idx, full, empty, count, proc2Dcache_addr_store,
           proc2Dcache_data_store, is_32_bit, is_16_bit, store_en
  );
endinterface

// File: rtl/store_queue.sv
// In-order store queue: allocate at dispatch, fill at execute, commit at retire, drain to D-cache.
// Latency: a committed+ready head presents store_en the cycle after its last state change; one pop per cycle.
// Backpressure: head held stable until store_accepted; alloc_en ignored while full (pre-edge count).
// Ports:
//   clock  - single clock, all state on posedge
//   reset  - synchronous active-low
//   sq     - store_queue_if.slave (dispatch, FU, ROB and cache-store signals)
module store_queue #(
  parameter int SQ_DEPTH = 8,
  parameter int IDX_W    = $clog2(SQ_DEPTH)
) (
  input logic          clock,
  input logic          reset,
  store_queue_if.slave sq
);

  localparam int PTR_W = IDX_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  // Per-entry state
  logic [SQ_DEPTH-1:0] valid_q, valid_d;
  logic [SQ_DEPTH-1:0] ready_q, ready_d;
  logic [SQ_DEPTH-1:0] cmtd_q, cmtd_d;
  logic [1:0]          size_q [SQ_DEPTH];
  logic [1:0]          size_d [SQ_DEPTH];
  logic [31:0]         addr_q [SQ_DEPTH];
  logic [31:0]         addr_d [SQ_DEPTH];
  logic [31:0]         data_q [SQ_DEPTH];
  logic [31:0]         data_d [SQ_DEPTH];

  // Pointers carry a wrap bit so full and empty are distinguishable
  ptr_t head_q, head_d;
  ptr_t cptr_q, cptr_d;
  ptr_t tail_q, tail_d;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] cptr_idx;
  logic [IDX_W-1:0] tail_idx;
  ptr_t             count_w;
  logic             full_w;
  logic             store_en_w;
  logic             do_pop;
  logic             do_commit;
  logic             do_alloc;
  logic             do_exec;
  ptr_t             cptr_post;
  ptr_t             flush_span;

  assign head_idx = head_q[IDX_W-1:0];
  assign cptr_idx = cptr_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign count_w    = tail_q - head_q;
  assign full_w     = (count_w == ptr_t'(SQ_DEPTH));
  assign store_en_w = valid_q[head_idx] & cmtd_q[head_idx] & ready_q[head_idx];

  assign do_pop    = store_en_w & sq.store_accepted;
  assign do_commit = sq.commit_en & (cptr_q != tail_q);
  // Flush owns the tail this cycle, so a same-cycle allocation is dropped.
  assign do_alloc  = sq.alloc_en & ~full_w & ~sq.flush;
  // Only a valid entry can be written; the tail slot is never valid when
  // allocatable, so execute-vs-allocate on one index resolves to allocate.
  assign do_exec   = sq.exec_en & valid_q[sq.exec_idx];

  // Commit is applied before flush truncation so a store retiring in the
  // flush cycle survives.
  assign cptr_post  = cptr_q + ptr_t'(do_commit);
  assign flush_span = tail_q - cptr_post;

  always_comb begin
    logic [IDX_W-1:0] off;
    off     = '0;
    valid_d = valid_q;
    ready_d = ready_q;
    cmtd_d  = cmtd_q;
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    cptr_d  = cptr_q;
    tail_d  = tail_q;

    if (do_exec) begin
      addr_d[sq.exec_idx]  = sq.exec_addr;
      data_d[sq.exec_idx]  = sq.exec_data;
      ready_d[sq.exec_idx] = 1'b1;
    end

    if (do_alloc) begin
      valid_d[tail_idx] = 1'b1;
      ready_d[tail_idx] = 1'b0;
      cmtd_d[tail_idx]  = 1'b0;
      size_d[tail_idx]  = sq.alloc_size;
      tail_d            = tail_q + ptr_t'(1);
    end

    if (do_commit) begin
      cmtd_d[cptr_idx] = 1'b1;
      cptr_d           = cptr_post;
    end

    if (do_pop) begin
      valid_d[head_idx] = 1'b0;
      ready_d[head_idx] = 1'b0;
      cmtd_d[head_idx]  = 1'b0;
      head_d            = head_q + ptr_t'(1);
    end

    // Squash every entry in [cptr_post, tail): distance from the commit
    // pointer, taken modulo the depth, below the uncommitted span.
    if (sq.flush) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        off = IDX_W'(i) - cptr_post[IDX_W-1:0];
        if ({1'b0, off} < flush_span) begin
          valid_d[i] = 1'b0;
          ready_d[i] = 1'b0;
        end
      end
      tail_d = cptr_post;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      ready_q <= '0;
      cmtd_q  <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        size_q[i] <= 2'b00;
        addr_q[i] <= 32'h0;
        data_q[i] <= 32'h0;
      end
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      cmtd_q  <= cmtd_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      cptr_q  <= cptr_d;
      tail_q  <= tail_d;
    end
  end

  assign sq.alloc_idx              = tail_idx;
  assign sq.full                   = full_w;
  assign sq.empty                  = (count_w == '0);
  assign sq.count                  = count_w;
  assign sq.store_en               = store_en_w;
  assign sq.proc2Dcache_addr_store = addr_q[head_idx];
  assign sq.proc2Dcache_data_store = data_q[head_idx];
  assign sq.is_32_bit              = size_q[head_idx][1];
  assign sq.is_16_bit              = (size_q[head_idx] == 2'b01);

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
// Ports: drives store_queue_if master side; clock/reset generated locally.
module tb_store_queue;
  localparam int D = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_queue_if #(.SQ_DEPTH(D)) sqi ();
  store_queue #(.SQ_DEPTH(D)) dut (.clock(clk), .reset(rst_n), .sq(sqi));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of live stores, oldest first. The first m_ncmt are committed.
  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    bit          ready;
  } m_ent_t;

  m_ent_t m_q[$];
  int     m_head = 0;
  int     m_ncmt = 0;
  bit     m_live = 1'b0;

  always @(posedge clk) begin : model
    int     n;
    int     p;
    bit     sen;
    bit     fl;
    m_ent_t e;
    if (!rst_n) begin
      m_q.delete();
      m_head = 0;
      m_ncmt = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      n   = m_q.size();
      sen = (n > 0) && (m_ncmt > 0) && m_q[0].ready;
      fl  = (n == D);
      if (sqi.exec_en) begin
        p = (int'(sqi.exec_idx) - m_head + D) % D;
        if (p < n) begin
          e       = m_q[p];
          e.addr  = sqi.exec_addr;
          e.data  = sqi.exec_data;
          e.ready = 1'b1;
          m_q[p]  = e;
        end
      end
      if (sqi.commit_en && m_ncmt < n) m_ncmt++;
      if (sqi.alloc_en && !fl && !sqi.flush) begin
        e.size  = sqi.alloc_size;
        e.addr  = 32'h0;
        e.data  = 32'h0;
        e.ready = 1'b0;
        m_q.push_back(e);
      end
      if (sen && sqi.store_accepted) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % D;
        m_ncmt--;
      end
      if (sqi.flush) begin
        while (m_q.size() > m_ncmt) void'(m_q.pop_back());
      end
    end
  end

  always @(negedge clk) begin : compare
    int n;
    bit exp_en;
    if (m_live) begin
      n      = m_q.size();
      exp_en = (n > 0) && (m_ncmt > 0) && m_q[0].ready;
      chk("m_store_en", 32'(sqi.store_en), 32'(exp_en));
      chk("m_count", 32'(sqi.count), 32'(n));
      chk("m_full", 32'(sqi.full), 32'(n == D));
      chk("m_empty", 32'(sqi.empty), 32'(n == 0));
      chk("m_alloc_idx", 32'(sqi.alloc_idx), 32'((m_head + n) % D));
      if (exp_en) begin
        chk("m_addr", sqi.proc2Dcache_addr_store, m_q[0].addr);
        chk("m_data", sqi.proc2Dcache_data_store, m_q[0].data);
        chk("m_is32", 32'(sqi.is_32_bit), 32'(m_q[0].size >= 2'b10));
        chk("m_is16", 32'(sqi.is_16_bit), 32'(m_q[0].size == 2'b01));
      end
    end
  end

  task automatic clear_in();
    sqi.alloc_en       = 1'b0;
    sqi.alloc_size     = 2'b00;
    sqi.exec_en        = 1'b0;
    sqi.exec_idx       = '0;
    sqi.exec_addr      = 32'h0;
    sqi.exec_data      = 32'h0;
    sqi.commit_en      = 1'b0;
    sqi.flush          = 1'b0;
    sqi.store_accepted = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_exec(input int idx, input logic [31:0] a, input logic [31:0] d);
    sqi.exec_en   = 1'b1;
    sqi.exec_idx  = idx[2:0];
    sqi.exec_addr = a;
    sqi.exec_data = d;
    step();
    sqi.exec_en = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_empty", 32'(sqi.empty), 32'd1);
    chk("rst_full", 32'(sqi.full), 32'd0);
    chk("rst_count", 32'(sqi.count), 32'd0);
    chk("rst_store_en", 32'(sqi.store_en), 32'd0);
    chk("rst_alloc_idx", 32'(sqi.alloc_idx), 32'd0);

    // Word store held for three stalled cycles, then accepted
    sqi.alloc_en = 1'b1; sqi.alloc_size = 2'b10; step(); clear_in();
    do_exec(0, 32'h1004, 32'hDEADBEEF);
    sqi.commit_en = 1'b1; step(); clear_in();
    repeat (3) begin
      chk("t1_store_en", 32'(sqi.store_en), 32'd1);
      chk("t1_addr", sqi.proc2Dcache_addr_store, 32'h1004);
      chk("t1_data", sqi.proc2Dcache_data_store, 32'hDEADBEEF);
      chk("t1_is32", 32'(sqi.is_32_bit), 32'd1);
      step();
    end
    sqi.store_accepted = 1'b1; step(); clear_in();
    chk("t1_pop_en", 32'(sqi.store_en), 32'd0);
    chk("t1_pop_empty", 32'(sqi.empty), 32'd1);

    // Byte then half, drained back to back
    sqi.alloc_en = 1'b1; sqi.alloc_size = 2'b00; step();
    sqi.alloc_size = 2'b01; step(); clear_in();
    do_exec(1, 32'h2003, 32'h000000AB);
    do_exec(2, 32'h2006, 32'h00001234);
    sqi.commit_en = 1'b1; step(); step(); clear_in();
    chk("t2_count0", 32'(sqi.count), 32'd2);
    chk("t2_addr0", sqi.proc2Dcache_addr_store, 32'h2003);
    chk("t2_flags0", {30'd0, sqi.is_32_bit, sqi.is_16_bit}, 32'd0);
    sqi.store_accepted = 1'b1; step();
    chk("t2_count1", 32'(sqi.count), 32'd1);
    chk("t2_en1", 32'(sqi.store_en), 32'd1);
    chk("t2_addr1", sqi.proc2Dcache_addr_store, 32'h2006);
    chk("t2_data1", sqi.proc2Dcache_data_store, 32'h1234);
    chk("t2_flags1", {30'd0, sqi.is_32_bit, sqi.is_16_bit}, 32'd1);
    step(); clear_in();
    chk("t2_count2", 32'(sqi.count), 32'd0);

    // Fill to full, reject overflow and same-cycle pop+alloc, then wrap
    pulse_reset();
    sqi.alloc_en = 1'b1; sqi.alloc_size = 2'b10;
    repeat (D) step();
    chk("t3_full", 32'(sqi.full), 32'd1);
    chk("t3_alloc_idx", 32'(sqi.alloc_idx), 32'd0);
    step();
    chk("t3_ovf_count", 32'(sqi.count), 32'd8);
    chk("t3_ovf_idx", 32'(sqi.alloc_idx), 32'd0);
    sqi.alloc_en = 1'b0;
    do_exec(0, 32'h3000, 32'h55);
    sqi.commit_en = 1'b1; step(); sqi.commit_en = 1'b0;
    chk("t3_en", 32'(sqi.store_en), 32'd1);
    sqi.store_accepted = 1'b1; sqi.alloc_en = 1'b1; step();
    sqi.store_accepted = 1'b0;
    chk("t3_pop_count", 32'(sqi.count), 32'd7);
    chk("t3_pop_idx", 32'(sqi.alloc_idx), 32'd0);
    step(); clear_in();
    chk("t3_wrap_count", 32'(sqi.count), 32'd8);
    chk("t3_wrap_idx", 32'(sqi.alloc_idx), 32'd1);

    // Flush with two committed entries of four
    pulse_reset();
    sqi.alloc_en = 1'b1; sqi.alloc_size = 2'b10;
    repeat (4) step();
    clear_in();
    do_exec(0, 32'h4000, 32'h40);
    do_exec(1, 32'h4004, 32'h41);
    sqi.commit_en = 1'b1; step(); step(); clear_in();
    chk("t4_en_pre", 32'(sqi.store_en), 32'd1);
    sqi.flush = 1'b1; step(); clear_in();
    chk("t4_count", 32'(sqi.count), 32'd2);
    chk("t4_alloc_idx", 32'(sqi.alloc_idx), 32'd2);
    chk("t4_en_post", 32'(sqi.store_en), 32'd1);
    sqi.store_accepted = 1'b1; step();
    chk("t4_addr2", sqi.proc2Dcache_addr_store, 32'h4004);
    step(); clear_in();
    chk("t4_empty", 32'(sqi.empty), 32'd1);

    // Commit before execute: drain waits for ready
    pulse_reset();
    sqi.alloc_en = 1'b1; sqi.alloc_size = 2'b11; step(); clear_in();
    sqi.commit_en = 1'b1; step(); clear_in();
    chk("t5_wait0", 32'(sqi.store_en), 32'd0);
    step();
    chk("t5_wait1", 32'(sqi.store_en), 32'd0);
    do_exec(0, 32'h5001, 32'h77);
    chk("t5_en", 32'(sqi.store_en), 32'd1);
    chk("t5_is32", 32'(sqi.is_32_bit), 32'd1);

    // Reset during an accepted drain
    sqi.store_accepted = 1'b1; rst_n = 1'b0; step();
    rst_n = 1'b1; clear_in();
    chk("t6_en", 32'(sqi.store_en), 32'd0);
    chk("t6_empty", 32'(sqi.empty), 32'd1);
    chk("t6_count", 32'(sqi.count), 32'd0);
    chk("t6_addr", sqi.proc2Dcache_addr_store, 32'h0);
    chk("t6_alloc_idx", 32'(sqi.alloc_idx), 32'd0);

    // Randomized traffic, checked by the compare process
    repeat (4000) begin
      rst_n              = ($urandom_range(0, 299) != 0);
      sqi.alloc_en       = ($urandom_range(0, 99) < 55);
      sqi.alloc_size     = 2'($urandom_range(0, 3));
      sqi.exec_en        = ($urandom_range(0, 99) < 50);
      sqi.exec_idx       = 3'($urandom_range(0, D - 1));
      sqi.exec_addr      = $urandom;
      sqi.exec_data      = $urandom;
      sqi.commit_en      = ($urandom_range(0, 99) < 40);
      sqi.flush          = ($urandom_range(0, 29) == 0);
      sqi.store_accepted = ($urandom_range(0, 99) < 60);
      step();
    end
    rst_n = 1'b1;
    clear_in();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
